// File: rtl/seq_tx_fsm_pkg.sv
// rtl/seq_tx_fsm_pkg.sv - state encodings and limits shared by the burst transmitter
package seq_tx_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  // Default pattern width, which is also the longest legal burst.
  localparam int MAX_LEN = 8;

  // det_count saturates here instead of wrapping.
  localparam logic [3:0] DET_MAX = 4'd15;

endpackage

// File: rtl/jkflipflop.sv
// rtl/jkflipflop.sv - JK flip-flop holding one state bit of the transmitter FSM
// Ports: clk, reset (sync, active-high, clears q), j/k (set/reset/toggle), q.
module jkflipflop (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/seq_tx_fsm.sv
// rtl/seq_tx_fsm.sv - serial burst transmitter feeding a sequence detector, counts its hits
// Ports: clk, reset (sync, active-high); start/pattern/len request a burst (MSB first);
//        det_in is the detector's same-cycle response to x_out; x_out/valid carry the bits;
//        busy covers SHIFT and DONE; done/err are one-cycle pulses; det_count counts hits.
module seq_tx_fsm
  import seq_tx_fsm_pkg::*;
#(
  parameter int WIDTH = MAX_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       len,
  input  logic             det_in,
  output logic             x_out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       det_count
);

  logic             q1;
  logic             q0;
  state_t           state;
  logic             j1, k1, j0, k0;
  logic             len_ok;
  logic             accept;
  logic             reject;
  logic             last;
  logic [WIDTH-1:0] shreg;
  logic [3:0]       cnt;
  logic             err_q;
  logic [3:0]       det_q;

  assign state = state_t'({q1, q0});

  jkflipflop u_state_hi (
    .clk   (clk),
    .reset (reset),
    .j     (j1),
    .k     (k1),
    .q     (q1)
  );

  jkflipflop u_state_lo (
    .clk   (clk),
    .reset (reset),
    .j     (j0),
    .k     (k0),
    .q     (q0)
  );

  always_comb begin
    len_ok = (len != 4'd0) && (len <= 4'(WIDTH));
    accept = (state == ST_IDLE) && start && len_ok;
    reject = (state == ST_IDLE) && start && !len_ok;
    last   = (cnt == 4'd1);

    // Transitions: IDLE->SHIFT on accept, SHIFT->DONE on the last bit,
    // DONE->IDLE and the unused 11->IDLE unconditionally.
    // lo bit: set only from IDLE; clear whenever hi is set or the last bit goes out.
    j0 = ~q1 & accept;
    k0 = q1 | last;
    // hi bit: set only when leaving SHIFT; never survives more than one cycle.
    j1 = q0 & last;
    k1 = 1'b1;

    x_out = 1'b0;
    valid = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_SHIFT: begin
        valid = 1'b1;
        busy  = 1'b1;
        x_out = shreg[WIDTH-1];
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= 4'd0;
      det_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      // A rejection is only possible from IDLE, so err can never overlap DONE.
      err_q <= reject;
      if (accept) begin
        shreg <= pattern;
        cnt   <= len;
        det_q <= 4'd0;
      end else if (state == ST_SHIFT) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        cnt   <= cnt - 4'd1;
        if (det_in && (det_q != DET_MAX)) begin
          det_q <= det_q + 4'd1;
        end
      end
    end
  end

  assign err       = err_q;
  assign det_count = det_q;

endmodule
